pi_ctl_sequencer: RTL and testbench
===================================

Name: pi_ctl_sequencer

Overview:
- Sits in the digital core between the CDR loop / JTAG override registers and the analog core's phase-interpolator control bus (`ctl_pi[Nout]`, `ctl_valid`).
- Arbitrates between two requesters: the CDR and a manual override.
- Slews every PI code toward its requested target in bounded circular steps, pulsing `ctl_valid` on each applied step.
- Waits a settle interval after the last step, then acknowledges the requester.

Parameters:
- Nout, 4: number of PI outputs (phases).
- Npi, 9: PI code width; codes are circular modulo 2^Npi.
- MAX_STEP, 4: maximum code change per PI per step; range 1..2^(Npi-1).
- SETTLE_CYC, 2: cycles held in SETTLE after the final step; range 0..255.

Ports:
- clk_adc  input  1  block clock (digital-core ADC-rate clock).
- rst  input  1  synchronous, active-high reset.
- cdr_req  input  1  CDR update request; a level held until cdr_ack.
- cdr_code  input  [Nout][Npi]  CDR target codes; must be stable while cdr_req is high.
- cdr_ack  output  1  one-cycle acknowledge to the CDR.
- ovr_en  input  1  override mode; while high, cdr_req is ignored.
- ovr_req  input  1  override update request; a level held until ovr_ack.
- ovr_code  input  [Nout][Npi]  override target codes.
- ovr_ack  output  1  one-cycle acknowledge to the override source.
- pi_ctl  output  [Nout][Npi]  registered PI control codes to the analog core.
- ctl_valid  output  1  one-cycle pulse, coincident with each pi_ctl change.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, pi_ctl all 0, targets 0, ctl_valid=0, cdr_ack=0, ovr_ack=0, busy=0. A reset mid-operation aborts immediately; no ack is issued and pi_ctl returns to 0.
- Only one clock and one reset. All outputs are registered, except cdr_ack, ovr_ack and busy, which are Moore decodes of state/owner.
- State IDLE:
  - Grant goes to the override if ovr_en && ovr_req, else to the CDR if !ovr_en && cdr_req.
  - On a grant: record the owner, go to LOAD.
- State LOAD (1 cycle): latch the owner's code into target[]. Go to STEP. If all target==pi_ctl, go directly to SETTLE.
- State STEP, per PI i, every cycle:
  - d = (target[i] - pi_ctl[i]) mod 2^Npi.
  - d==0: hold.
  - d <= 2^(Npi-1): pi_ctl[i] += min(d, MAX_STEP) mod 2^Npi. The tie d==2^(Npi-1) steps upward.
  - Otherwise: pi_ctl[i] -= min(2^Npi-d, MAX_STEP) mod 2^Npi.
  - ctl_valid=1 in every cycle where any PI changed.
  - When the next value equals target for all i, go to SETTLE.
- State SETTLE: count SETTLE_CYC cycles with pi_ctl frozen, then go to DONE. SETTLE_CYC=0 means exactly 1 cycle passing through.
- State DONE (1 cycle): assert the owner's ack, then go to IDLE.
  - The requester must drop req in the cycle after ack.
  - A req still high in IDLE is treated as a new request.
- Requests arriving while busy are not sampled until IDLE.
- Changes on cdr_code/ovr_code after LOAD are ignored.
- ovr_en changing mid-operation does not abort; the current owner completes.
- Latency for a request whose largest step count is K>0: grant cycle (IDLE) + LOAD + K STEP cycles + SETTLE_CYC + DONE. Ack comes K+SETTLE_CYC+2 cycles after the grant cycle.

Decomposition:
- Add to const_pack: Nout and Npi (already present), and a new PI_MAX_STEP and PI_SETTLE_CYC as defaults.
- Add a typedef for the state enum (IDLE, LOAD, STEP, SETTLE, DONE) and an owner enum (OWN_CDR, OWN_OVR).
- One sub-module, pi_code_stepper: combinational next-code and done flag for a single PI (circular distance, clamp). It is instantiated Nout times.

Test Plan:
- Basic slew: reset; cdr_code all =10, cdr_req=1. Require ctl_valid pulses with pi_ctl 4, 8, 10 (3 pulses), then SETTLE 2 cycles. Require cdr_ack 7 cycles after the grant cycle, and busy low the cycle after.
- Wrap-around: pi_ctl at 510 (via a prior request); request 3. Require the sequence 2, 3 (upward through 0), with no pass through 506.
- Downward and tie: from 0, request 500; require 508, 504, 500. From 0, request 256; require an upward step to 4 first.
- Priority: ovr_en=1, ovr_req and cdr_req both high with ovr_code=20 and cdr_code=40. Require pi_ctl to reach 20, ovr_ack to pulse, and cdr_ack to stay 0 throughout.
- Zero-delta: request equal to the current codes. Require no ctl_valid pulse, and ack 2+SETTLE_CYC cycles after the grant cycle.
- Reset mid-STEP: assert rst during the second step. Next cycle require pi_ctl=0, state IDLE, and no ack. A held req then restarts cleanly from 0.

Source files
------------

// File: rtl/pi_ctl_sequencer_pkg.sv
// Shared constants and state/owner types for the PI control sequencer.
package pi_ctl_sequencer_pkg;

   localparam int unsigned Nout          = 4;
   localparam int unsigned Npi           = 9;
   localparam int unsigned PI_MAX_STEP   = 4;
   localparam int unsigned PI_SETTLE_CYC = 2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STEP,
      SETTLE,
      DONE
   } state_t;

   typedef enum logic {
      OWN_CDR,
      OWN_OVR
   } owner_t;

endpackage

// File: rtl/pi_ctl_sequencer_stepper.sv
// Next PI code for one phase: moves along the shorter circular path,
// clamped to MAX_STEP, with ties (half-circle) resolved upward.
module pi_code_stepper #(
   parameter int unsigned Npi      = pi_ctl_sequencer_pkg::Npi,
   parameter int unsigned MAX_STEP = pi_ctl_sequencer_pkg::PI_MAX_STEP
) (
   input  logic [Npi-1:0] cur,
   input  logic [Npi-1:0] tgt,
   output logic [Npi-1:0] nxt,
   output logic           done
);

   localparam logic [Npi-1:0] HALF     = Npi'(1) << (Npi - 1);
   localparam logic [Npi-1:0] STEP_LIM = Npi'(MAX_STEP);

   logic [Npi-1:0] fwd;
   logic [Npi-1:0] back;
   logic [Npi-1:0] amt;

   always_comb begin
      fwd  = tgt - cur;
      back = cur - tgt;
      amt  = '0;
      nxt  = cur;
      if (fwd == '0) begin
         nxt = cur;
      end else if (fwd <= HALF) begin
         amt = (fwd < STEP_LIM) ? fwd : STEP_LIM;
         nxt = cur + amt;
      end else begin
         amt = (back < STEP_LIM) ? back : STEP_LIM;
         nxt = cur - amt;
      end
   end

   assign done = (nxt == tgt);

endmodule

// File: rtl/pi_ctl_sequencer.sv
// Arbitrates CDR vs. override updates and slews the PI control codes
// toward the granted target, then settles and acknowledges the owner.
module pi_ctl_sequencer #(
   parameter int unsigned Nout       = pi_ctl_sequencer_pkg::Nout,
   parameter int unsigned Npi        = pi_ctl_sequencer_pkg::Npi,
   parameter int unsigned MAX_STEP   = pi_ctl_sequencer_pkg::PI_MAX_STEP,
   parameter int unsigned SETTLE_CYC = pi_ctl_sequencer_pkg::PI_SETTLE_CYC
) (
   input  logic                     clk_adc,
   input  logic                     rst,
   input  logic                     cdr_req,
   input  logic [Nout-1:0][Npi-1:0] cdr_code,
   output logic                     cdr_ack,
   input  logic                     ovr_en,
   input  logic                     ovr_req,
   input  logic [Nout-1:0][Npi-1:0] ovr_code,
   output logic                     ovr_ack,
   output logic [Nout-1:0][Npi-1:0] pi_ctl,
   output logic                     ctl_valid,
   output logic                     busy
);

   import pi_ctl_sequencer_pkg::*;

   localparam int unsigned CNT_W = 8;

   state_t                   state;
   state_t                   state_nxt;
   owner_t                   owner;
   logic [Nout-1:0][Npi-1:0] target;
   logic [Nout-1:0][Npi-1:0] code_sel;
   logic [Nout-1:0][Npi-1:0] step_code;
   logic [Nout-1:0]          step_done;
   logic [CNT_W-1:0]         settle_cnt;
   logic                     grant_ovr;
   logic                     grant_cdr;
   logic                     load_eq;
   logic                     all_done;
   logic                     any_change;
   logic                     settle_last;

   assign grant_ovr   = ovr_en & ovr_req;
   assign grant_cdr   = ~ovr_en & cdr_req;
   assign code_sel    = (owner == OWN_OVR) ? ovr_code : cdr_code;
   assign load_eq     = (code_sel == pi_ctl);
   assign all_done    = &step_done;
   assign any_change  = (step_code != pi_ctl);
   // SETTLE always lasts at least one cycle, even with SETTLE_CYC == 0
   assign settle_last = ((32'(settle_cnt) + 32'd1) >= 32'(SETTLE_CYC));

   for (genvar i = 0; i < int'(Nout); i++) begin : g_step
      pi_code_stepper #(
         .Npi      (Npi),
         .MAX_STEP (MAX_STEP)
      ) u_stepper (
         .cur  (pi_ctl[i]),
         .tgt  (target[i]),
         .nxt  (step_code[i]),
         .done (step_done[i])
      );
   end

   always_ff @(posedge clk_adc) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (grant_ovr || grant_cdr) state_nxt = LOAD;
         LOAD:    state_nxt = load_eq ? SETTLE : STEP;
         STEP:    if (all_done) state_nxt = SETTLE;
         SETTLE:  if (settle_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      cdr_ack = 1'b0;
      ovr_ack = 1'b0;
      busy    = (state != IDLE);
      if (state == DONE) begin
         cdr_ack = (owner == OWN_CDR);
         ovr_ack = (owner == OWN_OVR);
      end
   end

   // Owner, target, PI codes and settle counter
   always_ff @(posedge clk_adc) begin
      if (rst) begin
         owner      <= OWN_CDR;
         target     <= '0;
         pi_ctl     <= '0;
         ctl_valid  <= 1'b0;
         settle_cnt <= '0;
      end else begin
         ctl_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_ovr)      owner <= OWN_OVR;
               else if (grant_cdr) owner <= OWN_CDR;
            end
            LOAD: begin
               target     <= code_sel;
               settle_cnt <= '0;
            end
            STEP: begin
               pi_ctl     <= step_code;
               ctl_valid  <= any_change;
               settle_cnt <= '0;
            end
            SETTLE:  settle_cnt <= settle_cnt + CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pi_ctl_sequencer.sv
// Scoreboard bench: requests push expected pulses/acks derived from a
// closed-form circular-slew model; a negedge monitor pops and compares.
module tb_pi_ctl_sequencer;
   import pi_ctl_sequencer_pkg::*;

   localparam int NO  = int'(Nout);
   localparam int NP  = int'(Npi);
   localparam int MS  = int'(PI_MAX_STEP);
   localparam int SC  = int'(PI_SETTLE_CYC);
   localparam int MOD = 1 << NP;

   typedef logic [NO-1:0][NP-1:0] vec_t;
   typedef struct { vec_t val; int cyc; } pulse_t;
   typedef struct { bit ovr; int cyc; vec_t fin; } ack_t;

   logic clk_adc = 1'b0;
   logic rst, cdr_req, ovr_en, ovr_req;
   vec_t cdr_code, ovr_code;
   logic cdr_ack, ovr_ack, ctl_valid, busy;
   vec_t pi_ctl;

   int     total = 0;
   int     bad   = 0;
   int     cyc   = 0;
   bit     chk_busy = 1'b0;
   pulse_t pulse_q[$];
   ack_t   ack_q[$];
   vec_t   model_pi;

   pi_ctl_sequencer dut (
      .clk_adc   (clk_adc),
      .rst       (rst),
      .cdr_req   (cdr_req),
      .cdr_code  (cdr_code),
      .cdr_ack   (cdr_ack),
      .ovr_en    (ovr_en),
      .ovr_req   (ovr_req),
      .ovr_code  (ovr_code),
      .ovr_ack   (ovr_ack),
      .pi_ctl    (pi_ctl),
      .ctl_valid (ctl_valid),
      .busy      (busy)
   );

   always #5 clk_adc = ~clk_adc;
   always @(posedge clk_adc) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic vec_t all_of(input int v);
      vec_t r;
      for (int i = 0; i < NO; i++) r[i] = NP'(v);
      return r;
   endfunction

   // Model: each PI takes the shorter arc (tie upward), j-th step sits at min(j*MS, dist)
   task automatic push_expect(input vec_t tgt, input bit ovr, input int g);
      int amt[NO];
      bit up[NO];
      int kmax;
      kmax = 0;
      for (int i = 0; i < NO; i++) begin
         int d, k;
         d = (int'(tgt[i]) - int'(model_pi[i]) + MOD) % MOD;
         up[i]  = (d <= MOD / 2);
         amt[i] = up[i] ? d : MOD - d;
         k = (amt[i] + MS - 1) / MS;
         if (k > kmax) kmax = k;
      end
      for (int j = 1; j <= kmax; j++) begin
         pulse_t p;
         for (int i = 0; i < NO; i++) begin
            int s, c;
            c = int'(model_pi[i]);
            s = (j * MS < amt[i]) ? j * MS : amt[i];
            p.val[i] = NP'((up[i] ? c + s : c + MOD - s) % MOD);
         end
         p.cyc = g + 2 + j;
         pulse_q.push_back(p);
      end
      ack_q.push_back('{ovr: ovr, cyc: g + kmax + SC + 2, fin: tgt});
      model_pi = tgt;
   endtask

   always @(negedge clk_adc) begin
      if (chk_busy) begin
         check("busy_after_ack", 64'(busy), 64'd0);
         chk_busy = 1'b0;
      end
      if (ctl_valid) begin
         if (pulse_q.size() == 0) check("pulse_unexpected", 64'(ctl_valid), 64'd0);
         else begin
            pulse_t p;
            p = pulse_q.pop_front();
            check("pulse_code", 64'(pi_ctl), 64'(p.val));
            check("pulse_cycle", 64'(cyc), 64'(p.cyc));
         end
      end
      if (cdr_ack || ovr_ack) begin
         if (ack_q.size() == 0) check("ack_unexpected", 64'({cdr_ack, ovr_ack}), 64'd0);
         else begin
            ack_t a;
            a = ack_q.pop_front();
            check("ack_owner", 64'({cdr_ack, ovr_ack}), a.ovr ? 64'd1 : 64'd2);
            check("ack_cycle", 64'(cyc), 64'(a.cyc));
            check("final_code", 64'(pi_ctl), 64'(a.fin));
            check("pulses_left_at_ack", 64'(pulse_q.size()), 64'd0);
            chk_busy = 1'b1;
         end
      end
   end

   task automatic wait_idle();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 400 && !seen; n++) begin
         @(negedge clk_adc);
         if (!busy) seen = 1'b1;
      end
      check("idle_reached", 64'(seen), 64'd1);
   endtask

   task automatic wait_ack();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 400 && !seen; n++) begin
         @(negedge clk_adc);
         if (cdr_ack || ovr_ack) seen = 1'b1;
      end
      check("ack_seen", 64'(seen), 64'd1);
      cdr_req = 1'b0;
      ovr_req = 1'b0;
   endtask

   task automatic issue(input bit en, input bit rc, input bit ro, input vec_t cc, input vec_t oc,
                        output int g);
      wait_idle();
      @(posedge clk_adc);
      #1;
      ovr_en   = en;
      cdr_code = cc;
      ovr_code = oc;
      cdr_req  = rc;
      ovr_req  = ro;
      g = cyc;
      if (en && ro)       push_expect(oc, 1'b1, g);
      else if (!en && rc) push_expect(cc, 1'b0, g);
   endtask

   task automatic run_req(input bit en, input bit rc, input bit ro, input vec_t cc, input vec_t oc);
      int g;
      issue(en, rc, ro, cc, oc, g);
      wait_ack();
   endtask

   initial begin
      int g;
      rst = 1'b1; cdr_req = 1'b0; ovr_req = 1'b0; ovr_en = 1'b0;
      cdr_code = '0; ovr_code = '0; model_pi = '0;
      repeat (2) @(posedge clk_adc);
      @(negedge clk_adc);
      check("rst_pi_ctl", 64'(pi_ctl), 64'd0);
      check("rst_valid", 64'(ctl_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_acks", 64'({cdr_ack, ovr_ack}), 64'd0);
      @(posedge clk_adc);
      #1 rst = 1'b0;

      // basic slew, wrap-around, downward, tie
      run_req(1'b0, 1'b1, 1'b0, all_of(10), '0);
      run_req(1'b0, 1'b1, 1'b0, all_of(510), '0);
      run_req(1'b0, 1'b1, 1'b0, all_of(3), '0);
      run_req(1'b0, 1'b1, 1'b0, all_of(0), '0);
      run_req(1'b0, 1'b1, 1'b0, all_of(500), '0);
      run_req(1'b0, 1'b1, 1'b0, all_of(0), '0);
      run_req(1'b0, 1'b1, 1'b0, all_of(256), '0);
      // override priority, then zero-delta
      run_req(1'b1, 1'b1, 1'b1, all_of(40), all_of(20));
      run_req(1'b0, 1'b1, 1'b0, all_of(20), '0);

      // reset during the second STEP cycle; held request restarts from 0
      issue(1'b0, 1'b1, 1'b0, all_of(100), '0, g);
      repeat (3) @(posedge clk_adc);
      #1 rst = 1'b1;
      @(posedge clk_adc);
      #1 rst = 1'b0;
      pulse_q.delete();
      ack_q.delete();
      model_pi = '0;
      g = cyc;
      push_expect(all_of(100), 1'b0, g);
      @(negedge clk_adc);
      check("abort_pi_ctl", 64'(pi_ctl), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_acks", 64'({cdr_ack, ovr_ack}), 64'd0);
      wait_ack();

      // randomized requests, mixing far, near and unchanged codes per phase
      for (int n = 0; n < 30; n++) begin
         vec_t tc, to;
         bit en, rc, ro;
         en = 1'($urandom_range(0, 1));
         rc = en ? 1'($urandom_range(0, 1)) : 1'b1;
         ro = en ? 1'b1 : 1'($urandom_range(0, 1));
         for (int i = 0; i < NO; i++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      tc[i] = NP'($urandom_range(0, MOD - 1));
            else if (sel == 1) tc[i] = NP'((int'(model_pi[i]) + MOD + int'($urandom_range(0, 24)) - 12) % MOD);
            else               tc[i] = model_pi[i];
            to[i] = NP'($urandom_range(0, MOD - 1));
         end
         if (en) run_req(en, rc, ro, to, tc);
         else    run_req(en, rc, ro, tc, to);
      end

      wait_idle();
      repeat (3) @(negedge clk_adc);
      check("pulse_q_empty", 64'(pulse_q.size()), 64'd0);
      check("ack_q_empty", 64'(ack_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
